program_loader: RTL

Boot-time loader directly upstream of the `Memory` block's write port. It receives a length-prefixed program image as a byte stream from a UART receiver through a valid/ready handshake and packs the bytes into little-endian words. It writes those words into memory using WORD write mode, checks an 8-bit checksum, and holds the CPU in reset until the image loads cleanly.

---
 rtl/program_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader
//
// Boot-time loader that sits in front of the memory write port. It takes a
// length-prefixed program image from a UART receiver over a valid/ready byte
// stream. The image is the length low byte, the length high byte, the payload
// bytes and a closing checksum byte. Payload bytes are packed little-endian
// into 32-bit words and written with WORD mode from BASE_ADDRESS upward. The
// CPU is held in reset until the whole image is loaded and the 8-bit sum of
// the payload plus the checksum byte is zero.
//
// Optional feature (macro LOADER_VERIFY_EN): after each write the word is read
// back with readMode=WORD and compared against what was written. A mismatch
// ends the load in ERROR. Without the macro, readMode is tied to NONE and
// dataOutput is ignored.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse; starts a load from IDLE, DONE or ERROR
//   rxData     incoming byte
//   rxValid    rxData is valid
//   rxReady    loader accepts a byte this cycle
//   address    memory byte address (word aligned)
//   data       write word; byte k is in data[8k+7:8k]
//   writeMode  3'h0 NONE / 3'h3 WORD
//   readMode   3'h0 NONE / 3'h3 WORD (verify only)
//   dataOutput memory read data (verify only)
//   holdCpu    keeps the CPU in reset
//   done       image loaded and checksum good (sticky)
//   error      load failed (sticky)
module program_loader #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          MAX_BYTES    = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic        rxReady,
    output logic [31:0] address,
    output logic [31:0] data,
    output logic [2:0]  writeMode,
    output logic [2:0]  readMode,
    input  logic [31:0] dataOutput,
    output logic        holdCpu,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] MODE_NONE = 3'h0;
    localparam logic [2:0] MODE_WORD = 3'h3;

    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, PAYLOAD, WRITE, VERIFY, NEXT, CHECKSUM, DONE, ERROR
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] len_reg;
    logic [16:0] count_reg;
    logic [7:0]  sum_reg;
    logic [31:0] address_reg;
    logic [31:0] data_reg;
    logic        relaunch_reg;
    logic        rx_ready_reg;
    logic [2:0]  write_mode_reg;
    logic        hold_cpu_reg;
    logic        done_reg;
    logic        error_reg;

    logic        accept;
    logic [15:0] len_full;
    logic        last_byte;

    assign accept    = rxValid && rx_ready_reg;
    assign len_full  = {rxData, len_reg[7:0]};
    // The byte being accepted now is the final payload byte.
    assign last_byte = (count_reg + 17'd1) == {1'b0, len_reg};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start || relaunch_reg) state_next = LEN_LO;
            LEN_LO:   if (accept) state_next = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (int'({16'h0000, len_full}) > MAX_BYTES) state_next = ERROR;
                    else if (len_full == 16'h0000)              state_next = CHECKSUM;
                    else                                        state_next = PAYLOAD;
                end
            end
            PAYLOAD:  if (accept && (count_reg[1:0] == 2'd3 || last_byte)) state_next = WRITE;
`ifdef LOADER_VERIFY_EN
            WRITE:    state_next = VERIFY;
            VERIFY:   state_next = (dataOutput != data_reg) ? ERROR : NEXT;
`else
            WRITE:    state_next = NEXT;
`endif
            NEXT:     state_next = (count_reg == {1'b0, len_reg}) ? CHECKSUM : PAYLOAD;
            CHECKSUM: begin
                if (accept) state_next = (8'(sum_reg + rxData) == 8'h00) ? DONE : ERROR;
            end
            DONE:     if (start) state_next = IDLE;
            ERROR:    if (start) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

`ifdef LOADER_VERIFY_EN
    logic [2:0] read_mode_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            len_reg        <= 16'h0000;
            count_reg      <= 17'd0;
            sum_reg        <= 8'h00;
            address_reg    <= BASE_ADDRESS;
            data_reg       <= 32'h0000_0000;
            relaunch_reg   <= 1'b0;
            rx_ready_reg   <= 1'b0;
            write_mode_reg <= MODE_NONE;
            hold_cpu_reg   <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
`ifdef LOADER_VERIFY_EN
            read_mode_reg  <= MODE_NONE;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    len_reg      <= 16'h0000;
                    count_reg    <= 17'd0;
                    sum_reg      <= 8'h00;
                    address_reg  <= BASE_ADDRESS;
                    data_reg     <= 32'h0000_0000;
                    relaunch_reg <= 1'b0;
                end
                LEN_LO: if (accept) len_reg[7:0] <= rxData;
                LEN_HI: if (accept) len_reg <= len_full;
                PAYLOAD: begin
                    if (accept) begin
                        data_reg[{count_reg[1:0], 3'b000} +: 8] <= rxData;
                        sum_reg   <= sum_reg + rxData;
                        count_reg <= count_reg + 17'd1;
                    end
                end
                NEXT: begin
                    address_reg <= address_reg + 32'd4;
                    data_reg    <= 32'h0000_0000;
                end
                // A start in a final state passes through IDLE so the
                // datapath is cleared, then continues to LEN_LO unprompted.
                DONE:  if (start) relaunch_reg <= 1'b1;
                ERROR: if (start) relaunch_reg <= 1'b1;
                default: ;
            endcase

            // Outputs are registered from the state being entered so they
            // line up with state_reg without any combinational decode.
            state_reg      <= state_next;
            rx_ready_reg   <= (state_next == LEN_LO) || (state_next == LEN_HI) ||
                              (state_next == PAYLOAD) || (state_next == CHECKSUM);
            write_mode_reg <= (state_next == WRITE) ? MODE_WORD : MODE_NONE;
            hold_cpu_reg   <= (state_next != DONE);
            done_reg       <= (state_next == DONE);
            error_reg      <= (state_next == ERROR);
`ifdef LOADER_VERIFY_EN
            read_mode_reg  <= (state_next == VERIFY) ? MODE_WORD : MODE_NONE;
`endif
        end
    end

    assign rxReady   = rx_ready_reg;
    assign address   = address_reg;
    assign data      = data_reg;
    assign writeMode = write_mode_reg;
    assign holdCpu   = hold_cpu_reg;
    assign done      = done_reg;
    assign error     = error_reg;

`ifdef LOADER_VERIFY_EN
    assign readMode = read_mode_reg;
`else
    logic unused_data_output;
    assign readMode           = MODE_NONE;
    assign unused_data_output = ^dataOutput;
`endif

endmodule
